dense_seq_ctrl: RTL and testbench

//  Sequencer for one int8 dense layer (B outputs, D-deep input, one input per 2 cycles).
//  Per frame: clears the dense accumulators, streams D features from a sync-read feature

---
 rtl/dense_seq_ctrl_if.sv | 37 +++
 rtl/dense_seq_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_dense_seq_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dense_seq_ctrl_if.sv
// Bus bundle between the dense-layer sequencer and its surroundings (feature buffer, dense layer, top FSM).
// No latency of its own; pure wiring with master (sequencer) and slave (environment) views.
// No backpressure: every transfer is a strobe or pulse; the dense layer must absorb one input per 2 cycles.
interface dense_seq_ctrl_if #(
   parameter int D          = 64,
   parameter int B          = 7,
   parameter int DATA_WIDTH = 8
);
   localparam int AW = (D > 1) ? $clog2(D) : 1;
   localparam int CW = (B > 1) ? $clog2(B) : 1;

   logic                         start_i;
   logic [AW-1:0]                feat_addr_o;
   logic signed [DATA_WIDTH-1:0] feat_data_i;
   logic                         dense_rstn_o;
   logic                         dense_valid_o;
   logic signed [DATA_WIDTH-1:0] dense_data_o;
   logic                         dense_valid_i;
   logic [DATA_WIDTH*B-1:0]      dense_data_i;
   logic                         busy_o;
   logic                         done_o;
   logic                         error_o;
   logic [CW-1:0]                class_o;
   logic signed [DATA_WIDTH-1:0] score_o;

   modport master (
      input  start_i, feat_data_i, dense_valid_i, dense_data_i,
      output feat_addr_o, dense_rstn_o, dense_valid_o, dense_data_o,
             busy_o, done_o, error_o, class_o, score_o
   );

   modport slave (
      output start_i, feat_data_i, dense_valid_i, dense_data_i,
      input  feat_addr_o, dense_rstn_o, dense_valid_o, dense_data_o,
             busy_o, done_o, error_o, class_o, score_o
   );
endinterface

// File: rtl/dense_seq_ctrl.sv
// Frame sequencer for one int8 dense layer: clear, stream D features, capture B scores, signed argmax.
// Latency start_i->done_o = 1 + 2*D + (WAIT cycles) + B + 1; all outputs registered.
// No backpressure: start_i is ignored unless idle; a silent dense layer ends the frame via timeout.
module dense_seq_ctrl #(
   parameter int D          = 64,
   parameter int B          = 7,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 32
) (
   input  logic              clk,
   input  logic              rstn,
   dense_seq_ctrl_if.master  bus
);
   localparam int AW = (D > 1) ? $clog2(D) : 1;
   localparam int CW = (B > 1) ? $clog2(B) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_WAIT,
      S_ARGMAX,
      S_DONE
   } state_t;

   state_t                       state_q;
   state_t                       state_d;

   // feature slot index and phase within the 2-cycle slot
   logic [AW-1:0]                idx_q;
   logic                         phase_q;
   // cycles spent in WAIT
   logic [TW-1:0]                wait_q;
   // class currently being examined by the argmax sweep
   logic [CW-1:0]                cls_q;

   logic signed [DATA_WIDTH-1:0] score_q [B];
   logic signed [DATA_WIDTH-1:0] best_q;
   logic [CW-1:0]                best_idx_q;

   logic                         feed_last;
   logic                         wait_last;
   logic                         argmax_last;
   logic                         timeout;
   logic                         take;
   logic signed [DATA_WIDTH-1:0] cand;
   logic signed [DATA_WIDTH-1:0] best_d;
   logic [CW-1:0]                best_idx_d;

   // Next-state logic plus the argmax compare for the class under examination.
   always_comb begin
      state_d     = state_q;
      feed_last   = phase_q && (idx_q == AW'(D - 1));
      wait_last   = (wait_q == TW'(TIMEOUT - 1));
      argmax_last = (cls_q == CW'(B - 1));
      timeout     = 1'b0;
      cand        = score_q[cls_q];
      // strict greater-than keeps the earlier (lower) index on ties
      take        = (cls_q == '0) || (cand > best_q);
      best_d      = take ? cand  : best_q;
      best_idx_d  = take ? cls_q : best_idx_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start_i) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            state_d = S_FEED;
         end
         S_FEED: begin
            if (feed_last) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.dense_valid_i) begin
               state_d = S_ARGMAX;
            end else if (wait_last) begin
               timeout = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_ARGMAX: begin
            if (argmax_last) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register; reset aborts any frame in progress.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Feature streaming: address in phase 0, buffer data registered to the dense layer after phase 1.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idx_q             <= '0;
         phase_q           <= 1'b0;
         bus.feat_addr_o   <= '0;
         bus.dense_valid_o <= 1'b0;
         bus.dense_data_o  <= '0;
      end else begin
         bus.dense_valid_o <= (state_q == S_FEED) && phase_q;
         if ((state_q == S_FEED) && phase_q) begin
            bus.dense_data_o <= bus.feat_data_i;
         end
         case (state_q)
            S_CLEAR: begin
               idx_q           <= '0;
               phase_q         <= 1'b0;
               bus.feat_addr_o <= '0;
            end
            S_FEED: begin
               phase_q <= ~phase_q;
               // index only advances inside the frame; leaving FEED is what ends the sweep
               if (phase_q && !feed_last) begin
                  idx_q           <= idx_q + AW'(1);
                  bus.feat_addr_o <= idx_q + AW'(1);
               end
            end
            default: begin
               phase_q <= 1'b0;
            end
         endcase
      end
   end

   // WAIT cycle counter, restarted whenever the sequencer is elsewhere.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wait_q <= '0;
      end else if (state_q == S_WAIT) begin
         wait_q <= wait_q + TW'(1);
      end else begin
         wait_q <= '0;
      end
   end

   // Capture the packed dense results on the result pulse seen in WAIT only.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < B; k++) begin
            score_q[k] <= '0;
         end
      end else if ((state_q == S_WAIT) && bus.dense_valid_i) begin
         for (int k = 0; k < B; k++) begin
            score_q[k] <= bus.dense_data_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Argmax sweep: one class per cycle, running best kept in best_q/best_idx_q.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cls_q      <= '0;
         best_q     <= '0;
         best_idx_q <= '0;
      end else if (state_q == S_ARGMAX) begin
         cls_q      <= cls_q + CW'(1);
         best_q     <= best_d;
         best_idx_q <= best_idx_d;
      end else begin
         cls_q      <= '0;
      end
   end

   // Registered status outputs derived from the upcoming state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.busy_o       <= 1'b0;
         bus.done_o       <= 1'b0;
         bus.dense_rstn_o <= 1'b0;
      end else begin
         bus.busy_o       <= (state_d != S_IDLE);
         bus.done_o       <= (state_d == S_DONE);
         bus.dense_rstn_o <= (state_d != S_CLEAR);
      end
   end

   // Sticky error: raised on WAIT timeout, dropped when a new frame is accepted.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.error_o <= 1'b0;
      end else if ((state_q == S_IDLE) && bus.start_i) begin
         bus.error_o <= 1'b0;
      end else if (timeout) begin
         bus.error_o <= 1'b1;
      end
   end

   // Result registers update together with done_o and hold until the next one.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.class_o <= '0;
         bus.score_o <= '0;
      end else if ((state_q == S_ARGMAX) && argmax_last) begin
         bus.class_o <= best_idx_d;
         bus.score_o <= best_d;
      end
   end

endmodule

// File: tb/tb_dense_seq_ctrl.sv
// Bench for dense_seq_ctrl: randomized frames against a frame-level schedule model.
// Model predicts every output per cycle from frame start, response latency and buffer/result contents.
// Feature buffer and dense layer are modelled as simple bench processes.
module tb_dense_seq_ctrl;
   localparam int D       = 4;
   localparam int B       = 3;
   localparam int DW      = 8;
   localparam int TIMEOUT = 16;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   dense_seq_ctrl_if #(.D(D), .B(B), .DATA_WIDTH(DW)) bus ();

   dense_seq_ctrl #(.D(D), .B(B), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.master)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // stimulus-controlled environment
   int fbuf [D];
   int res  [B];
   int resp_lat = 2;
   bit resp_en  = 1'b1;

   // observations recorded by the monitor
   int strobes [$];
   int done_cnt = 0;
   int done_cyc = 0;
   int start_cyc = 0;
   int end_cyc = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
      end
   endtask

   // argmax by the rule: largest value, lowest index among equals
   function automatic void ref_argmax(input int r [B], output int ci, output int sc);
      sc = -1000;
      for (int k = 0; k < B; k++) if (r[k] > sc) sc = r[k];
      ci = -1;
      for (int k = B - 1; k >= 0; k--) if (r[k] == sc) ci = k;
   endfunction

   // feature buffer (1-cycle read latency) and dense-layer responder
   initial begin
      int addr_prev = 0;
      int scnt = 0;
      int cd = -1;
      bus.feat_data_i   = '0;
      bus.dense_valid_i = 1'b0;
      bus.dense_data_i  = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.feat_data_i = 8'(fbuf[addr_prev]);
         addr_prev = int'(bus.feat_addr_o);
         for (int k = 0; k < B; k++) bus.dense_data_i[k*DW +: DW] = 8'(res[k]);
         bus.dense_valid_i = 1'b0;
         if (!rstn) begin
            scnt = 0;
            cd = -1;
         end else begin
            if (cd > 0) cd--;
            if (cd == 0) begin
               bus.dense_valid_i = 1'b1;
               cd = -1;
            end
            if (bus.dense_valid_o) begin
               scnt++;
               if (scnt == D) begin
                  scnt = 0;
                  if (resp_en) begin
                     if (resp_lat == 0) bus.dense_valid_i = 1'b1;
                     else cd = resp_lat;
                  end
               end
            end
         end
      end
   end

   // frame-level model and per-cycle compare
   initial begin
      bit f_act = 1'b0;
      bit f_en = 1'b0;
      int s = 0;
      int f_lat = 0;
      int f_feat [D];
      int f_res [B];
      int m_cls = 0;
      int m_sc = 0;
      bit m_err = 1'b0;
      bit rlow_prev = 1'b1;
      forever begin
         bit rst_exp;
         bit e_busy, e_v, e_drstn, e_done, e_addr_chk;
         int e_data, e_addr, rel, done_rel, to_rel;
         @(posedge clk);
         #2;
         if (bus.dense_valid_o) strobes.push_back(int'(bus.dense_data_o));
         if (bus.done_o) begin
            done_cnt++;
            done_cyc = cyc;
         end
         rst_exp = !rstn || rlow_prev;
         e_busy = 1'b0; e_v = 1'b0; e_drstn = 1'b1; e_done = 1'b0;
         e_addr_chk = 1'b0; e_data = 0; e_addr = 0;
         if (rst_exp) begin
            f_act = 1'b0; m_cls = 0; m_sc = 0; m_err = 1'b0;
            e_drstn = 1'b0; e_addr_chk = 1'b1;
            chk("rst_dense_data", int'(bus.dense_data_o), 0);
         end else if (f_act) begin
            rel = cyc - s;
            done_rel = 3 + 2*D + f_lat + B;
            to_rel = 2 + 2*D + TIMEOUT;
            e_busy = 1'b1;
            if (rel == 1) e_drstn = 1'b0;
            if (rel >= 2 && rel <= 2*D && rel % 2 == 0) begin
               e_addr_chk = 1'b1;
               e_addr = (rel - 2) / 2;
            end
            if (rel >= 4 && rel <= 2 + 2*D && rel % 2 == 0) begin
               e_v = 1'b1;
               e_data = f_feat[(rel - 4) / 2];
            end
            if (f_en && rel == done_rel) begin
               e_done = 1'b1;
               ref_argmax(f_res, m_cls, m_sc);
               f_act = 1'b0;
            end
            if (!f_en && rel == to_rel) begin
               e_busy = 1'b0;
               m_err = 1'b1;
               f_act = 1'b0;
            end
         end
         chk("busy_o", int'(bus.busy_o), int'(e_busy));
         chk("dense_valid_o", int'(bus.dense_valid_o), int'(e_v));
         chk("dense_rstn_o", int'(bus.dense_rstn_o), int'(e_drstn));
         chk("done_o", int'(bus.done_o), int'(e_done));
         chk("error_o", int'(bus.error_o), int'(m_err));
         chk("class_o", int'(bus.class_o), m_cls);
         chk("score_o", int'(bus.score_o), m_sc);
         if (e_v) chk("dense_data_o", int'(bus.dense_data_o), e_data);
         if (e_addr_chk) chk("feat_addr_o", int'(bus.feat_addr_o), e_addr);
         if (bus.start_i && rstn && !e_busy && !f_act) begin
            f_act = 1'b1;
            s = cyc;
            f_feat = fbuf;
            f_res = res;
            f_lat = resp_lat;
            f_en = resp_en;
            m_err = 1'b0;
         end
         rlow_prev = !rstn;
      end
   end

   // Runs one frame from the current (idle) cycle; returns at the first idle cycle after it.
   task automatic run_frame(input bit ign);
      bit fin = 1'b0;
      strobes.delete();
      done_cnt = 0;
      start_cyc = cyc;
      bus.start_i = 1'b1;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      for (int i = 1; i <= 200 && !fin; i++) begin
         if (!bus.busy_o) begin
            fin = 1'b1;
            end_cyc = cyc;
         end else begin
            bus.start_i = ign && (i == 6 || i == 2*D + 3);
            @(posedge clk);
            #1;
            bus.start_i = 1'b0;
         end
      end
      chk("frame_ends_within_bound", int'(fin), 1);
   endtask

   initial begin
      bit got2;
      bus.start_i = 1'b0;
      fbuf = '{0, 0, 0, 0};
      res = '{0, 0, 0};
      repeat (3) @(posedge clk);
      #1;
      chk("reset_dense_rstn", int'(bus.dense_rstn_o), 0);
      chk("reset_busy", int'(bus.busy_o), 0);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      chk("post_reset_dense_rstn", int'(bus.dense_rstn_o), 1);

      // basic frame
      fbuf = '{1, 2, 3, 4}; res = '{5, -3, 9}; resp_lat = 2; resp_en = 1'b1;
      run_frame(1'b0);
      chk("t1_strobes", strobes.size(), 4);
      for (int k = 0; k < strobes.size() && k < D; k++) chk("t1_strobe_data", strobes[k], k + 1);
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_latency", done_cyc - start_cyc, 16);
      chk("t1_end", end_cyc - start_cyc, 17);
      chk("t1_class", int'(bus.class_o), 2);
      chk("t1_score", int'(bus.score_o), 9);

      // ties and all-negative
      res = '{7, 7, -128};
      run_frame(1'b0);
      chk("t2_tie_class", int'(bus.class_o), 0);
      chk("t2_tie_score", int'(bus.score_o), 7);
      res = '{-5, -2, -9};
      run_frame(1'b0);
      chk("t2_neg_class", int'(bus.class_o), 1);
      chk("t2_neg_score", int'(bus.score_o), -2);

      // timeout then recovery
      resp_en = 1'b0;
      run_frame(1'b0);
      chk("t3_error", int'(bus.error_o), 1);
      chk("t3_no_done", done_cnt, 0);
      chk("t3_timeout_cycle", end_cyc - start_cyc, 2 + 2*D + TIMEOUT);
      resp_en = 1'b1;
      res = '{1, 3, 2};
      run_frame(1'b0);
      chk("t3_error_cleared", int'(bus.error_o), 0);
      chk("t3_recover_done", done_cnt, 1);
      chk("t3_recover_class", int'(bus.class_o), 1);

      // start pulses during FEED and WAIT are ignored
      run_frame(1'b1);
      chk("t4_strobes", strobes.size(), 4);
      chk("t4_done_cnt", done_cnt, 1);

      // reset in the middle of FEED
      fbuf = '{1, 2, 3, 4}; res = '{5, -3, 9};
      strobes.delete();
      bus.start_i = 1'b1;
      got2 = 1'b0;
      for (int i = 0; i < 40 && !got2; i++) begin
         @(posedge clk);
         #1;
         bus.start_i = 1'b0;
         if (strobes.size() >= 2) got2 = 1'b1;
      end
      chk("t5_two_strobes_seen", int'(got2), 1);
      rstn = 1'b0;
      #1;
      chk("t5_reset_drstn", int'(bus.dense_rstn_o), 0);
      chk("t5_reset_valid", int'(bus.dense_valid_o), 0);
      chk("t5_reset_busy", int'(bus.busy_o), 0);
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      run_frame(1'b0);
      chk("t5_strobes", strobes.size(), 4);
      chk("t5_class", int'(bus.class_o), 2);

      // back-to-back frames
      run_frame(1'b0);
      fbuf = '{0, 0, 0, 1}; res = '{-1, 4, 0};
      run_frame(1'b0);
      chk("t6_class", int'(bus.class_o), 1);
      chk("t6_score", int'(bus.score_o), 4);
      for (int k = 0; k < strobes.size() && k < D; k++) chk("t6_strobe_data", strobes[k], (k == 3) ? 1 : 0);

      // randomized frames
      for (int n = 0; n < 24; n++) begin
         for (int k = 0; k < D; k++) fbuf[k] = int'($urandom_range(0, 255)) - 128;
         for (int k = 0; k < B; k++) begin
            if (n % 3 == 0) res[k] = int'($urandom_range(0, 3)) - 2;
            else res[k] = int'($urandom_range(0, 255)) - 128;
         end
         resp_lat = int'($urandom_range(0, 10));
         resp_en = ($urandom_range(0, 7) != 0);
         run_frame($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 2) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      resp_en = 1'b1;
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
